wb_arbiter: RTL

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arb_pkg.sv | 22 ++
 rtl/wb_arbiter_if.sv | 36 +++
 rtl/wb_arb_fifo.sv | 68 ++++++
 rtl/wb_arbiter.sv | 109 ++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// rtl/wb_arb_pkg.sv - shared constants and entry type for the writeback arbiter
// Holds the MDU FIFO depth, derived pointer/count widths, the zero-register
// address and the packed FIFO entry layout {live, waddr, wdata}.
package wb_arb_pkg;

  localparam int FIFO_DEPTH = 2;
  localparam int PTR_W      = $clog2(FIFO_DEPTH);
  localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic        live;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } entry_t;

  function automatic logic [31:0] onehot_reg(input logic [4:0] r);
    onehot_reg = 32'd1 << r;
  endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// rtl/wb_arbiter_if.sv - writeback arbiter bus bundle
// Signals: pipeline writeback (in_pipe_*), MDU result handshake (in_mdu_*,
// out_mdu_ready), register-file port (out_rd_*), busy scoreboard and perf
// counters. Modport slave is the arbiter, master is whoever drives it.
interface wb_arbiter_if;
  import wb_arb_pkg::*;

  logic [4:0]  in_pipe_waddr;
  logic        in_pipe_wena;
  logic [31:0] in_pipe_wdata;
  logic        in_mdu_valid;
  logic [4:0]  in_mdu_waddr;
  logic [31:0] in_mdu_wdata;
  logic        out_mdu_ready;
  logic [4:0]  out_rd_waddr;
  logic        out_rd_wena;
  logic [31:0] out_rd_wdata;
  logic [31:0] out_busy;
  logic [31:0] out_perf_conflict;
  logic [31:0] out_perf_full;

  modport master (
    output in_pipe_waddr, in_pipe_wena, in_pipe_wdata,
    output in_mdu_valid, in_mdu_waddr, in_mdu_wdata,
    input  out_mdu_ready, out_rd_waddr, out_rd_wena, out_rd_wdata,
    input  out_busy, out_perf_conflict, out_perf_full
  );

  modport slave (
    input  in_pipe_waddr, in_pipe_wena, in_pipe_wdata,
    input  in_mdu_valid, in_mdu_waddr, in_mdu_wdata,
    output out_mdu_ready, out_rd_waddr, out_rd_wena, out_rd_wdata,
    output out_busy, out_perf_conflict, out_perf_full
  );

endinterface

// File: rtl/wb_arb_fifo.sv
// rtl/wb_arb_fifo.sv - in-order MDU result FIFO with WAW kill
// Ports: clk, rst_n (sync active-low); push_en/push_waddr/push_wdata store a
// live entry; pop_en retires the head; kill_en/kill_waddr clear the live bit
// of every stored entry targeting that register. Outputs: head entry, count,
// and the next-state live/waddr per slot for the registered busy vector.
module wb_arb_fifo
  import wb_arb_pkg::*;
(
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             push_en,
  input  logic [4:0]                       push_waddr,
  input  logic [31:0]                      push_wdata,
  input  logic                             pop_en,
  input  logic                             kill_en,
  input  logic [4:0]                       kill_waddr,
  output entry_t                           head,
  output logic [CNT_W-1:0]                 count,
  output logic [FIFO_DEPTH-1:0]            live_nxt,
  output logic [FIFO_DEPTH-1:0][4:0]       waddr_nxt
);

  entry_t [FIFO_DEPTH-1:0] ent_q, ent_d;
  logic   [PTR_W-1:0]      wr_q, rd_q;
  logic   [CNT_W-1:0]      cnt_q, cnt_d;

  // Kill is applied before push so a result accepted in the same cycle as a
  // pipeline write to the same register is stored live. Popping clears live,
  // so live alone marks "occupied and still wanted".
  always_comb begin
    ent_d = ent_q;
    if (kill_en) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        if (ent_q[i].waddr == kill_waddr) ent_d[i].live = 1'b0;
      end
    end
    if (pop_en) ent_d[rd_q].live = 1'b0;
    if (push_en) ent_d[wr_q] = '{live: 1'b1, waddr: push_waddr, wdata: push_wdata};
    cnt_d = cnt_q + CNT_W'(push_en) - CNT_W'(pop_en);
  end

  always_comb begin
    live_nxt  = '0;
    waddr_nxt = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      live_nxt[i]  = ent_d[i].live;
      waddr_nxt[i] = ent_d[i].waddr;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ent_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      ent_q <= ent_d;
      cnt_q <= cnt_d;
      if (push_en) wr_q <= wr_q + PTR_W'(1);
      if (pop_en)  rd_q <= rd_q + PTR_W'(1);
    end
  end

  assign head  = ent_q[rd_q];
  assign count = cnt_q;

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - register-file write port arbiter (pipeline vs MDU)
// Ports: clk, rst_n (sync active-low), bus (wb_arbiter_if.slave).
// Pipeline writes own the port combinationally; MDU results queue in a
// 2-entry FIFO and drain when the port is free. Optional macro
// WB_ARB_PERF_EN adds saturating conflict/full counters; otherwise those
// outputs are tied to zero.
module wb_arbiter
  import wb_arb_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  wb_arbiter_if.slave bus
);

  entry_t                     head;
  logic [CNT_W-1:0]           fifo_cnt;
  logic [FIFO_DEPTH-1:0]      live_nxt;
  logic [FIFO_DEPTH-1:0][4:0] waddr_nxt;

  logic        pipe_we;
  logic        ready;
  logic        push_en;
  logic        pop_en;
  logic        fifo_nonempty;
  logic [31:0] busy_q, busy_nxt;

  assign pipe_we       = bus.in_pipe_wena && (bus.in_pipe_waddr != REG_ZERO);
  assign fifo_nonempty = (fifo_cnt != '0);
  // Gated by rst_n so nothing is accepted or drained while reset is held.
  assign ready   = rst_n && (fifo_cnt < CNT_W'(FIFO_DEPTH));
  assign push_en = bus.in_mdu_valid && ready && (bus.in_mdu_waddr != REG_ZERO);
  // Dead heads pop too; they just never raise the write enable.
  assign pop_en  = rst_n && !pipe_we && fifo_nonempty;

  wb_arb_fifo u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_en    (push_en),
    .push_waddr (bus.in_mdu_waddr),
    .push_wdata (bus.in_mdu_wdata),
    .pop_en     (pop_en),
    .kill_en    (pipe_we),
    .kill_waddr (bus.in_pipe_waddr),
    .head       (head),
    .count      (fifo_cnt),
    .live_nxt   (live_nxt),
    .waddr_nxt  (waddr_nxt)
  );

  always_comb begin
    bus.out_rd_wena  = 1'b0;
    bus.out_rd_waddr = '0;
    bus.out_rd_wdata = '0;
    if (pipe_we) begin
      bus.out_rd_wena  = 1'b1;
      bus.out_rd_waddr = bus.in_pipe_waddr;
      bus.out_rd_wdata = bus.in_pipe_wdata;
    end else if (pop_en && head.live) begin
      bus.out_rd_wena  = 1'b1;
      bus.out_rd_waddr = head.waddr;
      bus.out_rd_wdata = head.wdata;
    end
  end

  // Registered from the FIFO's next state, so the vector always mirrors the
  // entries currently held.
  always_comb begin
    busy_nxt = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (live_nxt[i]) busy_nxt = busy_nxt | onehot_reg(waddr_nxt[i]);
    end
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_nxt;
  end

  assign bus.out_mdu_ready = ready;
  assign bus.out_busy      = busy_q;

`ifdef WB_ARB_PERF_EN
  logic [31:0] perf_conflict_q;
  logic [31:0] perf_full_q;
  logic        conflict_hit;
  logic        full_hit;

  assign conflict_hit = pipe_we && fifo_nonempty && head.live;
  assign full_hit     = bus.in_mdu_valid && !ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_conflict_q <= '0;
      perf_full_q     <= '0;
    end else begin
      if (conflict_hit && (perf_conflict_q != '1)) perf_conflict_q <= perf_conflict_q + 32'd1;
      if (full_hit && (perf_full_q != '1))         perf_full_q     <= perf_full_q + 32'd1;
    end
  end

  assign bus.out_perf_conflict = perf_conflict_q;
  assign bus.out_perf_full     = perf_full_q;
`else
  assign bus.out_perf_conflict = '0;
  assign bus.out_perf_full     = '0;
`endif

endmodule
